// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O peripheral cluster: PS/2 frame size and
// default sizing of the running light and scan-code FIFO.
package board_io_pkg;

    localparam int PS2_FRAME_BITS       = 11;
    localparam int DEFAULT_FIFO_DEPTH   = 8;
    localparam int DEFAULT_LIGHT_PERIOD = 5_000_000;

endpackage

// File: rtl/board_io_peripherals_ps2_rx.sv
// PS/2 keyboard receiver: clock synchronizer, frame capture with start/stop/parity
// validation, and a scan-code FIFO that keeps one slot empty to tell full from empty.
module ps2_rx
    import board_io_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] kbd_data,
    output logic       kbd_ready,
    output logic       kbd_overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]       ps2_sync;
    logic [9:0]       buffer;
    logic [3:0]       count;
    logic [7:0]       fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] w_ptr;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next;

    logic sample;
    logic frame_end;
    logic frame_valid;
    logic fifo_full;
    logic do_write;
    logic do_pop;

    // ps2_data is taken raw: it is stable for the whole low phase of ps2_clk.
    assign sample      = ps2_sync[2] & ~ps2_sync[1];
    assign frame_end   = sample && (count == LAST_BIT);
    assign frame_valid = ~buffer[0] & ps2_data & (^buffer[9:1]);
    assign w_next      = w_ptr + PTR_W'(1);
    assign fifo_full   = (w_next == r_ptr);
    assign do_write    = frame_end && frame_valid && !fifo_full;
    assign do_pop      = !nextdata_n && kbd_ready;

    assign kbd_ready = (w_ptr != r_ptr);
    assign kbd_data  = fifo[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_sync     <= 3'b000;
            buffer       <= '0;
            count        <= '0;
            w_ptr        <= '0;
            r_ptr        <= '0;
            kbd_overflow <= 1'b0;
        end else begin
            ps2_sync <= {ps2_sync[1:0], ps2_clk};
            if (sample) begin
                if (count < LAST_BIT) begin
                    buffer[count] <= ps2_data;
                    count         <= count + 4'd1;
                end else begin
                    count <= '0;
                end
            end
            if (do_write) begin
                w_ptr <= w_next;
            end
            if (frame_end && frame_valid && fifo_full) begin
                kbd_overflow <= 1'b1;
            end
            if (do_pop) begin
                r_ptr <= r_ptr + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            fifo[w_ptr] <= buffer[8:1];
        end
    end

endmodule

// File: rtl/board_io_peripherals.sv
// Board I/O cluster: 2-bit switch-field mux, rotating one-hot running light and
// the PS/2 keyboard receiver.
module board_io_peripherals
    import board_io_pkg::*;
#(
    parameter int LIGHT_PERIOD = DEFAULT_LIGHT_PERIOD,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mux_sel,
    input  logic [1:0]  mux_x0,
    input  logic [1:0]  mux_x1,
    input  logic [1:0]  mux_x2,
    input  logic [1:0]  mux_x3,
    output logic [1:0]  mux_f,
    output logic [15:0] led,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        nextdata_n,
    output logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        kbd_overflow
);

    localparam logic [31:0] CNT_LAST = 32'(LIGHT_PERIOD - 1);

    logic [31:0] cnt;

    always_comb begin
        mux_f = mux_x0;
        case (mux_sel)
            2'd0: mux_f = mux_x0;
            2'd1: mux_f = mux_x1;
            2'd2: mux_f = mux_x2;
            2'd3: mux_f = mux_x3;
            default: mux_f = mux_x0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            led <= 16'h0001;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            led <= {led[14:0], led[15]};
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    ps2_rx #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_ps2_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .nextdata_n  (nextdata_n),
        .kbd_data    (kbd_data),
        .kbd_ready   (kbd_ready),
        .kbd_overflow(kbd_overflow)
    );

endmodule

// File: tb/tb_board_io_peripherals.sv
// Directed bench for board_io_peripherals: mux sweep, running light with a short
// period, and PS/2 frames covering good, corrupt, overflow and mid-frame reset cases.
module tb_board_io_peripherals;

    logic        clk;
    logic        rst;
    logic [1:0]  mux_sel;
    logic [1:0]  mux_x0;
    logic [1:0]  mux_x1;
    logic [1:0]  mux_x2;
    logic [1:0]  mux_x3;
    logic [1:0]  mux_f;
    logic [15:0] led;
    logic        ps2_clk;
    logic        ps2_data;
    logic        nextdata_n;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        kbd_overflow;

    int checks = 0;
    int errors = 0;

    board_io_peripherals #(
        .LIGHT_PERIOD(4),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mux_sel     (mux_sel),
        .mux_x0      (mux_x0),
        .mux_x1      (mux_x1),
        .mux_x2      (mux_x2),
        .mux_x3      (mux_x3),
        .mux_f       (mux_f),
        .led         (led),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .nextdata_n  (nextdata_n),
        .kbd_data    (kbd_data),
        .kbd_ready   (kbd_ready),
        .kbd_overflow(kbd_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] sel);
        mux_sel = sel;
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set during the high phase, then an 8-cycle low phase.
    // With pop_at_fall the pop lands on the same edge that writes the frame.
    task automatic send_bit(input logic b, input logic pop_at_fall);
        ps2_data = b;
        wait_cycles(8);
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            wait_cycles(2);
            nextdata_n = 1'b0;
            wait_cycles(1);
            nextdata_n = 1'b1;
            wait_cycles(5);
        end else begin
            wait_cycles(8);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic bad_parity,
                              input logic bad_stop, input logic pop_at_end);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i], 1'b0);
        send_bit((~^code) ^ bad_parity, 1'b0);
        send_bit(~bad_stop, pop_at_end);
        wait_cycles(6);
    endtask

    task automatic pop_once();
        nextdata_n = 1'b0;
        wait_cycles(1);
        nextdata_n = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        rst        = 1'b1;
        mux_sel    = 2'd0;
        mux_x0     = 2'd0;
        mux_x1     = 2'd1;
        mux_x2     = 2'd2;
        mux_x3     = 2'd3;
        ps2_clk    = 1'b1;
        ps2_data   = 1'b1;
        nextdata_n = 1'b1;
        wait_cycles(3);

        checkOutput("reset_led", 32'(led), 32'h0001);
        checkOutput("reset_ready", 32'(kbd_ready), 32'd0);
        checkOutput("reset_overflow", 32'(kbd_overflow), 32'd0);

        for (int s = 0; s < 4; s++) begin
            applyStimulus(2'(s));
            checkOutput($sformatf("mux_sel%0d", s), 32'(mux_f), 32'(s));
        end
        mux_x2 = 2'd1;
        applyStimulus(2'd2);
        checkOutput("mux_x2_change", 32'(mux_f), 32'd1);

        @(negedge clk);
        rst = 1'b0;
        wait_cycles(3);
        checkOutput("led_hold", 32'(led), 32'h0001);
        wait_cycles(1);
        checkOutput("led_step1", 32'(led), 32'h0002);
        wait_cycles(4 * 13);
        checkOutput("led_step14", 32'(led), 32'h4000);
        wait_cycles(4);
        checkOutput("led_step15", 32'(led), 32'h8000);
        wait_cycles(4);
        checkOutput("led_wrap", 32'(led), 32'h0001);

        $display("[TB] valid frame 0x1C");
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        checkOutput("rx1c_ready", 32'(kbd_ready), 32'd1);
        checkOutput("rx1c_data", 32'(kbd_data), 32'h1C);
        pop_once();
        checkOutput("rx1c_popped", 32'(kbd_ready), 32'd0);
        pop_once();
        checkOutput("pop_empty", 32'(kbd_ready), 32'd0);

        $display("[TB] corrupt frames");
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        checkOutput("bad_parity", 32'(kbd_ready), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        checkOutput("bad_stop", 32'(kbd_ready), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        checkOutput("rxf0_ready", 32'(kbd_ready), 32'd1);
        checkOutput("rxf0_data", 32'(kbd_data), 32'hF0);
        pop_once();
        checkOutput("rxf0_popped", 32'(kbd_ready), 32'd0);

        $display("[TB] fifo fill");
        for (int i = 1; i <= 7; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        checkOutput("seven_no_overflow", 32'(kbd_overflow), 32'd0);
        send_frame(8'h08, 1'b0, 1'b0, 1'b0);
        checkOutput("full_overflow", 32'(kbd_overflow), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            checkOutput($sformatf("drain_ready%0d", i), 32'(kbd_ready), 32'd1);
            checkOutput($sformatf("drain_data%0d", i), 32'(kbd_data), 32'(i));
            pop_once();
        end
        checkOutput("drained_ready", 32'(kbd_ready), 32'd0);
        checkOutput("overflow_sticky", 32'(kbd_overflow), 32'd1);

        $display("[TB] reset mid-frame");
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);
        checkOutput("midreset_overflow", 32'(kbd_overflow), 32'd0);
        checkOutput("midreset_ready", 32'(kbd_ready), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        checkOutput("rx5a_ready", 32'(kbd_ready), 32'd1);
        checkOutput("rx5a_data", 32'(kbd_data), 32'h5A);

        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        checkOutput("popwrite_ready", 32'(kbd_ready), 32'd1);
        checkOutput("popwrite_data", 32'(kbd_data), 32'h33);
        pop_once();
        checkOutput("popwrite_single", 32'(kbd_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_io_peripherals.md
# board_io_peripherals

Board-level I/O peripheral cluster that sits beside the VGA and seven-segment paths under the top level. It contains three independent functions:
- a rotating one-hot 16-LED "running light";
- a 4-to-1 multiplexer of 2-bit switch fields;
- a PS/2 keyboard receiver that validates frames and queues scan codes in an 8-entry FIFO.

All state is clocked by the single system clock.

## Interface
Parameters:
- LIGHT_PERIOD, 5_000_000, clock cycles per LED rotation step (≥2).
- FIFO_DEPTH, 8, scan-code FIFO entries (power of two; one entry always kept empty).

Ports:
- clk  in  1  system clock. One clock; all flops on its rising edge.
- rst  in  1  reset. Synchronous, active-high.
- mux_sel  in  2  mux select.
- mux_x0, mux_x1, mux_x2, mux_x3  in  2 each  mux data inputs.
- mux_f  out  2  selected mux input.
- led  out  16  running-light pattern.
- ps2_clk  in  1  raw PS/2 clock (asynchronous).
- ps2_data  in  1  raw PS/2 data.
- nextdata_n  in  1  active-low pop request.
- kbd_data  out  8  scan code at FIFO head.
- kbd_ready  out  1  FIFO non-empty.
- kbd_overflow  out  1  sticky overflow flag.

## Operation
Mux:
- Purely combinational.
- mux_f = mux_x0/x1/x2/x3 for mux_sel = 0/1/2/3.
- Unaffected by reset.

Running light:
- 32-bit cycle counter cnt.
- When cnt == LIGHT_PERIOD-1: cnt←0 and led←{led[14:0], led[15]} (rotate left).
- Otherwise cnt←cnt+1.
- On reset: led=16'h0001, cnt=0.

PS/2 receiver:
- Synchronizer: ps2_clk goes through a 3-bit shift register, ps2_sync←{ps2_sync[1:0], ps2_clk}.
- Falling-edge detect: sample = ps2_sync[2] & ~ps2_sync[1].
- Frame capture: on each sample, if count < 10 then buffer[count]←ps2_data and count++. Data is sampled raw, since it is stable while PS/2 clock is low.
- Frame check: on the sample where count == 10, count←0 and the frame is valid iff all of the following hold:
  - buffer[0] == 0 (start bit);
  - ps2_data == 1 (stop bit);
  - ^buffer[9:1] == 1 (odd parity over data and parity bits).
- Valid frame: if the FIFO is not full, write buffer[8:1] at w_ptr and increment w_ptr. If full, discard the frame and set kbd_overflow.
- Invalid frame: silently discarded.
- Full condition: w_ptr+1 == r_ptr (mod FIFO_DEPTH). Usable capacity is FIFO_DEPTH-1 = 7.
- Pop: when nextdata_n == 0 and kbd_ready, r_ptr increments. A pop request while empty is ignored.
- Simultaneous valid-frame write and pop in the same cycle:
  - both take effect;
  - the full check uses pre-update pointers, so a full FIFO still drops the frame.
- kbd_overflow is sticky until reset.
- Reset: pointers, count and ps2_sync cleared (ps2_sync←3'b000), kbd_overflow=0, so kbd_ready=0.

## Timing
- mux_f: zero latency.
- led: first rotation occurs LIGHT_PERIOD cycles after reset deassertion.
- kbd_ready = (w_ptr != r_ptr) and kbd_data = fifo[r_ptr], both combinational from registers.
- Write latency: kbd_ready rises on the cycle after the clk edge that detected the 11th falling edge. Detection itself lags the pin by 2–3 clk cycles due to the synchronizer.
- Pop latency: kbd_data shows the next entry one cycle after the pop edge. Hold nextdata_n low for exactly one cycle per pop; each low cycle with kbd_ready high pops one entry.
- Reset mid-frame: partial frame is abandoned and the next falling edge is treated as a start bit.
- Constraint: PS/2 clock (10–16.7 kHz) must be much slower than clk; each PS/2 clock phase spans ≥3 clk cycles.

## Structure
Shared package `board_io_pkg` holds:
- PS2_FRAME_BITS=11;
- default FIFO_DEPTH;
- default LIGHT_PERIOD.

One sub-module, `ps2_rx`: synchronizer, frame capture, parity check and FIFO, exposing kbd_data/kbd_ready/kbd_overflow/nextdata_n. The mux and running light stay inline in the top of this block.

## Test plan
- Mux: sweep mux_sel 0..3 with x0=0, x1=1, x2=2, x3=3 -> mux_f = 0, 1, 2, 3 in the same cycle.
- Running light, LIGHT_PERIOD=4: release reset -> led = 0001 for 4 cycles, then 0002. After 16 steps it returns to 0001; 8000 wraps to 0001.
- PS/2 valid frame: send scan code 0x1C (parity 0) -> kbd_ready=1 and kbd_data=0x1C. Pulse nextdata_n low 1 cycle -> kbd_ready=0.
- PS/2 error frames: one frame with wrong parity, one with stop bit 0 -> no write, kbd_ready stays 0, next valid frame 0xF0 received correctly.
- FIFO full: send 8 valid frames (codes 0x01..0x08) without popping -> 7 stored, kbd_overflow=1. Pops return 0x01..0x07, then kbd_ready=0. kbd_overflow stays 1 until rst.
- Reset mid-frame: assert rst after 5 bits, then send 0x5A -> kbd_data=0x5A. Pop plus simultaneous write leaves count unchanged.
